// File: rtl/gate_bist_pkg.sv
// Shared state encoding and common 2-input truth tables for the gate BIST checker.
package gate_bist_pkg;

  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_SETTLE_ENC = 2'd1;
  localparam logic [1:0] ST_CHECK_ENC  = 2'd2;
  localparam logic [1:0] ST_DONE_ENC   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE_ENC,
    S_SETTLE = ST_SETTLE_ENC,
    S_CHECK  = ST_CHECK_ENC,
    S_DONE   = ST_DONE_ENC
  } bist_state_t;

  // Bit [v] is the expected output for input vector v = {a,b}.
  localparam logic [3:0] TT_AND2 = 4'b1000;
  localparam logic [3:0] TT_OR2  = 4'b1110;
  localparam logic [3:0] TT_XOR2 = 4'b0110;

endpackage

// File: rtl/gate_bist_vec_gen.sv
// Vector and settle counters: vec is the registered GUT stimulus; settle_done marks the last hold cycle.
// Latency: vec/cnt update on the edge after clear/advance; no backpressure, the FSM drives every step.
module gate_bist_vec_gen
  import gate_bist_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            settle_en,
  input  logic            advance,
  output logic [N_IN-1:0] vec,
  output logic            last_vec,
  output logic            settle_done
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      vec <= '0;
      cnt <= '0;
    end else if (advance) begin
      vec <= vec + N_IN'(1);
      cnt <= '0;
    end else if (settle_en && !settle_done) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign settle_done = (cnt == CNT_MAX);
  assign last_vec    = (vec == {N_IN{1'b1}});

endmodule

// File: rtl/gate_bist_checker.sv
// On-chip BIST sweeping all N_IN-bit vectors into a gate and comparing against TRUTH_TABLE.
// Latency: done rises 2**N_IN*(SETTLE+1) edges after the accepting start; start ignored while busy.
// Optional first-failure log under GATE_BIST_FAIL_LOG_EN.
module gate_bist_checker
  import gate_bist_pkg::*;
#(
  parameter int                      N_IN        = 2,
  parameter logic [(1<<N_IN)-1:0]    TRUTH_TABLE = TT_AND2,
  parameter int                      SETTLE      = 1,
  parameter int                      ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N_IN-1:0]  dut_in,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
`ifdef GATE_BIST_FAIL_LOG_EN
  ,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic             first_fail_vld
`endif
);

  bist_state_t     state, state_nxt;
  logic            clear, settle_en, advance, chk;
  logic [N_IN-1:0] vec;
  logic            last_vec, settle_done, mismatch;

  gate_bist_vec_gen #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_vec_gen (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .settle_en   (settle_en),
    .advance     (advance),
    .vec         (vec),
    .last_vec    (last_vec),
    .settle_done (settle_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    settle_en = 1'b0;
    advance   = 1'b0;
    chk       = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          clear     = 1'b1;
          state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        settle_en = 1'b1;
        if (settle_done) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        chk = 1'b1;
        if (last_vec) begin
          state_nxt = S_DONE;
        end else begin
          advance   = 1'b1;
          state_nxt = S_SETTLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // dut_out is only trusted on the check cycle; X elsewhere is harmless.
  assign mismatch = chk && (dut_out !== TRUTH_TABLE[vec]);

  always_ff @(posedge clk) begin
    if (rst || clear)
      err_count <= '0;
    else if (mismatch && (err_count != {ERR_W{1'b1}}))
      err_count <= err_count + ERR_W'(1);
  end

`ifdef GATE_BIST_FAIL_LOG_EN
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      first_fail_vec <= '0;
      first_fail_vld <= 1'b0;
    end else if (mismatch && !first_fail_vld) begin
      first_fail_vec <= vec;
      first_fail_vld <= 1'b1;
    end
  end
`endif

  assign dut_in = vec;
  assign busy   = (state == S_SETTLE) || (state == S_CHECK);
  assign done   = (state == S_DONE);
  assign pass   = done && (err_count == '0);

endmodule

// File: tb/tb_gate_bist_checker.sv
// Directed bench for gate_bist_checker: default instance plus a SETTLE=3/ERR_W=1 saturation instance.
module tb_gate_bist_checker;
  import gate_bist_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start6 = 1'b0;
  logic [1:0] dut_in, dut_in6;
  logic       dut_out;
  logic       busy, done, pass;
  logic [7:0] err_count;
  logic       busy6, done6, pass6;
  logic [0:0] err6;
  int         gut_mode = 0;  // 0 AND, 1 OR, 2 stuck-0, 3 stuck-1
`ifdef GATE_BIST_FAIL_LOG_EN
  logic [1:0] ffv, ffv6;
  logic       ffl, ffl6;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (gut_mode)
      0:       dut_out = dut_in[1] & dut_in[0];
      1:       dut_out = dut_in[1] | dut_in[0];
      2:       dut_out = 1'b0;
      default: dut_out = 1'b1;
    endcase
  end

  gate_bist_checker #(.N_IN(2), .TRUTH_TABLE(TT_AND2), .SETTLE(1), .ERR_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count)
`ifdef GATE_BIST_FAIL_LOG_EN
    , .first_fail_vec(ffv), .first_fail_vld(ffl)
`endif
  );

  gate_bist_checker #(.N_IN(2), .TRUTH_TABLE(4'b1111), .SETTLE(3), .ERR_W(1)) u_dut6 (
    .clk(clk), .rst(rst), .start(start6), .dut_in(dut_in6), .dut_out(1'b0),
    .busy(busy6), .done(done6), .pass(pass6), .err_count(err6)
`ifdef GATE_BIST_FAIL_LOG_EN
    , .first_fail_vec(ffv6), .first_fail_vld(ffl6)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Drive start for exactly one rising edge; returns #1 after the accepting edge.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count edges after the accepting edge until done, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  int lat;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_dut_in", dut_in, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    rst = 1'b0;

    // 1: AND gate, each vector held 2 cycles, done at edge 8
    gut_mode = 0;
    pulse_start();
    check("t1_busy0", busy, 1);
    check("t1_vec_e0", dut_in, 0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("t1_vec_e%0d", k), dut_in, (k < 8) ? k / 2 : 3);
      if (k == 7) check("t1_done_e7", done, 0);
    end
    check("t1_done_e8", done, 1);
    check("t1_busy_e8", busy, 0);
    check("t1_err", err_count, 0);
    check("t1_pass", pass, 1);

    // 2: AND table vs OR gate -> vectors 1 and 2 mismatch
    gut_mode = 1;
    pulse_start();
    wait_done(lat);
    check("t2_lat", lat, 8);
    check("t2_err", err_count, 2);
    check("t2_pass", pass, 0);
`ifdef GATE_BIST_FAIL_LOG_EN
    check("t2_ffv", ffv, 1);
    check("t2_ffl", ffl, 1);
`endif

    // 3: stuck-at faults
    gut_mode = 2;
    pulse_start();
    wait_done(lat);
    check("t3_s0_err", err_count, 1);
`ifdef GATE_BIST_FAIL_LOG_EN
    check("t3_s0_ffv", ffv, 3);
`endif
    gut_mode = 3;
    pulse_start();
`ifdef GATE_BIST_FAIL_LOG_EN
    check("t3_ffl_clr", ffl, 0);
`endif
    wait_done(lat);
    check("t3_s1_err", err_count, 3);
    check("t3_s1_pass", pass, 0);
`ifdef GATE_BIST_FAIL_LOG_EN
    check("t3_s1_ffv", ffv, 0);
`endif

    // 4: reset on the 5th edge of a sweep aborts cleanly
    gut_mode = 1;
    pulse_start();
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("t4_err_pre", err_count, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    check("t4_dut_in", dut_in, 0);
    check("t4_err", err_count, 0);
    gut_mode = 0;
    pulse_start();
    wait_done(lat);
    check("t4_lat", lat, 8);
    check("t4_pass", pass, 1);

    // 5: start while busy ignored; start in DONE restarts
    gut_mode = 1;
    pulse_start();
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1 lat++;
      start = (lat == 2);
    end
    start = 1'b0;
    check("t5_lat", lat, 8);
    check("t5_err", err_count, 2);
    check("t5_dut_in_hold", dut_in, 3);
    pulse_start();
    check("t5_re_done", done, 0);
    check("t5_re_busy", busy, 1);
    check("t5_re_err", err_count, 0);
    check("t5_re_dut_in", dut_in, 0);
    wait_done(lat);
    check("t5_re_lat", lat, 8);

    // 6: SETTLE=3, 1-bit saturating counter, all four vectors mismatch
    @(negedge clk);
    start6 = 1'b1;
    @(posedge clk);
    #1 start6 = 1'b0;
    lat = 0;
    while (!done6 && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    check("t6_lat", lat, 16);
    check("t6_err", err6, 1);
    check("t6_pass", pass6, 0);
`ifdef GATE_BIST_FAIL_LOG_EN
    check("t6_ffv", ffv6, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
